// File: rtl/uart_rx_fsm_pkg.sv
// Shared types and constants for the UART receive frame controller.
package uart_rx_fsm_pkg;
  localparam int DATA_W = 8;
  localparam int EDGE_W = 6;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Expected parity bit for the captured byte; odd=1 selects odd parity.
  function automatic logic par_calc(input logic [DATA_W-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction
endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// Per-bit edge counter and data-bit counter for the UART receive FSM.
module uart_rx_edge_bit_cnt
  import uart_rx_fsm_pkg::*;
#(
  parameter int PRESCALE = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              load,
  input  logic              bit_clr,
  input  logic              bit_inc,
  output logic [EDGE_W-1:0] edge_cnt,
  output logic [2:0]        bit_cnt,
  output logic              bit_done
);
  localparam logic [EDGE_W-1:0] LAST = EDGE_W'(PRESCALE - 1);

  assign bit_done = en && (edge_cnt == LAST);

  // load wins over the wrap: a start seen on the final stop edge is edge 0 of the new frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      if (load)          edge_cnt <= EDGE_W'(1);
      else if (!en)      edge_cnt <= '0;
      else if (bit_done) edge_cnt <= '0;
      else               edge_cnt <= edge_cnt + EDGE_W'(1);

      if (bit_clr)       bit_cnt <= '0;
      else if (bit_inc)  bit_cnt <= bit_cnt + 3'd1;
    end
  end
endmodule

// File: rtl/uart_rx_fsm.sv
// UART receive frame controller: start detect, bit sequencing, parity/stop checks, byte publish.
module uart_rx_fsm
  import uart_rx_fsm_pkg::*;
#(
  parameter int PRESCALE = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              rx_in,
  input  logic              PAR_EN,
  input  logic              PAR_TYP,
  input  logic              sampled_bit,
  output logic [EDGE_W-1:0] edge_cnt,
  output logic              dat_samp_en,
  output logic [DATA_W-1:0] P_DATA,
  output logic              data_valid,
  output logic              par_err,
  output logic              stp_err
);
  state_t            state, state_nxt;
  logic [2:0]        bit_cnt;
  logic              bit_done;
  logic              cnt_en;
  logic              detect;
  logic              par_en_q, par_typ_q;
  logic              perr;
  logic [DATA_W-1:0] shift;

  assign cnt_en      = (state != IDLE);
  assign dat_samp_en = cnt_en;
  assign detect      = (state == IDLE && !rx_in) ||
                       (state == STOP && bit_done && !rx_in);

  uart_rx_edge_bit_cnt #(.PRESCALE(PRESCALE)) u_cnt (
    .clk      (CLK),
    .rst_n    (RST),
    .en       (cnt_en),
    .load     (detect),
    .bit_clr  (state == START && bit_done),
    .bit_inc  (state == DATA && bit_done),
    .edge_cnt (edge_cnt),
    .bit_cnt  (bit_cnt),
    .bit_done (bit_done)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (!rx_in) state_nxt = START;
      START:  if (bit_done) state_nxt = sampled_bit ? IDLE : DATA;
      DATA:   if (bit_done && bit_cnt == 3'd7) state_nxt = par_en_q ? PARITY : STOP;
      PARITY: if (bit_done) state_nxt = STOP;
      STOP:   if (bit_done) state_nxt = rx_in ? IDLE : START;
      default: state_nxt = IDLE;
    endcase
  end

  // Frame datapath; pulses default low so each lasts exactly one cycle.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      perr       <= 1'b0;
      shift      <= '0;
      P_DATA     <= '0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
      if (detect) begin
        par_en_q  <= PAR_EN;
        par_typ_q <= PAR_TYP;
        perr      <= 1'b0;
      end
      if (bit_done) begin
        case (state)
          DATA:   shift[bit_cnt] <= sampled_bit;
          PARITY: perr <= (sampled_bit != par_calc(shift, par_typ_q));
          STOP: begin
            if (sampled_bit && !perr) begin
              data_valid <= 1'b1;
              P_DATA     <= shift;
            end else begin
              par_err <= perr;
              stp_err <= !sampled_bit;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule
